// File: rtl/approx_wallace_final_adder_pipe.sv
// Final carry-propagate adder for the approximate 8-bit Wallace multiplier.
// Two-stage valid/ready pipeline; the low APPROX_LSBS result bits use lower-part OR.
module approx_wallace_final_adder_pipe #(
  parameter int APPROX_LSBS = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] row_a,
  input  logic [15:0] row_b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] product,
  output logic        out_ovf
);

  logic       s2_free;
  logic       s1_adv;
  logic       in_xfer;
  logic       out_xfer;
  logic       carry;
  logic [7:0] lo_sum_calc;
  logic       c8_calc;
  logic [8:0] hi_sum;

  logic       s1_valid_q, s1_valid_d;
  logic [7:0] lo_sum_q,   lo_sum_d;
  logic       c8_q,       c8_d;
  logic [7:0] hi_a_q,     hi_a_d;
  logic [7:0] hi_b_q,     hi_b_d;
  logic       s2_valid_q, s2_valid_d;
  logic [15:0] product_q, product_d;
  logic       out_ovf_q,  out_ovf_d;

  // Low byte: OR below APPROX_LSBS (last a&b there becomes the injected carry), exact ripple above
  always_comb begin
    carry       = 1'b0;
    lo_sum_calc = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (i < APPROX_LSBS) begin
        lo_sum_calc[i] = row_a[i] | row_b[i];
        carry          = row_a[i] & row_b[i];
      end else begin
        lo_sum_calc[i] = row_a[i] ^ row_b[i] ^ carry;
        carry          = (row_a[i] & row_b[i]) | (carry & (row_a[i] ^ row_b[i]));
      end
    end
    c8_calc = carry;
  end

  // Upper byte adder fed from stage-1 registers; bit 8 is the carry out of bit 15
  always_comb begin
    hi_sum = {1'b0, hi_a_q} + {1'b0, hi_b_q} + {8'h00, c8_q};
  end

  // Handshake control and next-state selection for both stages
  always_comb begin
    s2_free  = !s2_valid_q || out_ready;
    s1_adv   = s1_valid_q && s2_free;
    in_ready = !s1_valid_q || s2_free;
    in_xfer  = in_valid && in_ready;
    out_xfer = s2_valid_q && out_ready;

    s1_valid_d = s1_valid_q;
    lo_sum_d   = lo_sum_q;
    c8_d       = c8_q;
    hi_a_d     = hi_a_q;
    hi_b_d     = hi_b_q;
    s2_valid_d = s2_valid_q;
    product_d  = product_q;
    out_ovf_d  = out_ovf_q;

    if (in_xfer) begin
      s1_valid_d = 1'b1;
      lo_sum_d   = lo_sum_calc;
      c8_d       = c8_calc;
      hi_a_d     = row_a[15:8];
      hi_b_d     = row_b[15:8];
    end else if (s1_adv) begin
      s1_valid_d = 1'b0;
    end else begin
      s1_valid_d = s1_valid_q;
    end

    if (s1_adv) begin
      s2_valid_d = 1'b1;
      product_d  = {hi_sum[7:0], lo_sum_q};
      out_ovf_d  = hi_sum[8];
    end else if (out_xfer) begin
      s2_valid_d = 1'b0;
    end else begin
      s2_valid_d = s2_valid_q;
    end
  end

  // Pipeline registers; reset drops all in-flight data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      lo_sum_q   <= 8'h00;
      c8_q       <= 1'b0;
      hi_a_q     <= 8'h00;
      hi_b_q     <= 8'h00;
      s2_valid_q <= 1'b0;
      product_q  <= 16'h0000;
      out_ovf_q  <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      lo_sum_q   <= lo_sum_d;
      c8_q       <= c8_d;
      hi_a_q     <= hi_a_d;
      hi_b_q     <= hi_b_d;
      s2_valid_q <= s2_valid_d;
      product_q  <= product_d;
      out_ovf_q  <= out_ovf_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign product   = product_q;
  assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_approx_wallace_final_adder_pipe.sv
// Directed bench: an exact (APPROX_LSBS=0) and an approximate (APPROX_LSBS=4)
// instance share stimulus; expectations are hand-computed constants.
module tb_approx_wallace_final_adder_pipe;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [15:0] row_a;
  logic [15:0] row_b;
  logic        out_ready;

  logic        e_in_ready, e_out_valid, e_out_ovf;
  logic [15:0] e_product;
  logic        a_in_ready, a_out_valid, a_out_ovf;
  logic [15:0] a_product;

  int n_checks;
  int n_pass;

  approx_wallace_final_adder_pipe #(.APPROX_LSBS(0)) u_exact (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(e_in_ready),
    .row_a(row_a), .row_b(row_b), .out_valid(e_out_valid), .out_ready(out_ready),
    .product(e_product), .out_ovf(e_out_ovf)
  );

  approx_wallace_final_adder_pipe #(.APPROX_LSBS(4)) u_apx (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(a_in_ready),
    .row_a(row_a), .row_b(row_b), .out_valid(a_out_valid), .out_ready(out_ready),
    .product(a_product), .out_ovf(a_out_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One isolated transfer; returns with the result visible on out_valid
  task automatic run_one(input logic [15:0] a, input logic [15:0] b);
    in_valid = 1'b1;
    row_a    = a;
    row_b    = b;
    step();
    in_valid = 1'b0;
    chk("lat_not_early", {31'd0, e_out_valid}, 32'd0);
    step();
    chk("lat_valid_e", {31'd0, e_out_valid}, 32'd1);
    chk("lat_valid_a", {31'd0, a_out_valid}, 32'd1);
  endtask

  initial begin
    n_checks  = 0;
    n_pass    = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    row_a     = 16'h0000;
    row_b     = 16'h0000;
    out_ready = 1'b1;
    #2;
    chk("rst_out_valid", {31'd0, e_out_valid}, 32'd0);
    chk("rst_product",   {16'd0, a_product},   32'h0000);
    chk("rst_ovf",       {31'd0, a_out_ovf},   32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("rst_in_ready", {31'd0, e_in_ready}, 32'd1);

    // Test 1: c8 crosses the stage boundary
    run_one(16'h00FF, 16'h0001);
    chk("t1_prod_e", {16'd0, e_product}, 32'h0100);
    chk("t1_ovf_e",  {31'd0, e_out_ovf}, 32'd0);

    // Test 2: carry out of bit 15 vs. OR-approximated low nibble
    run_one(16'hFFFF, 16'h0001);
    chk("t2_prod_e", {16'd0, e_product}, 32'h0000);
    chk("t2_ovf_e",  {31'd0, e_out_ovf}, 32'd1);
    chk("t2_prod_a", {16'd0, a_product}, 32'hFFFF);
    chk("t2_ovf_a",  {31'd0, a_out_ovf}, 32'd0);

    // Test 3: approximate low bits and injected a3&b3 carry
    run_one(16'h0003, 16'h0001);
    chk("t3a_prod_a", {16'd0, a_product}, 32'h0003);
    chk("t3a_prod_e", {16'd0, e_product}, 32'h0004);
    run_one(16'h0008, 16'h0008);
    chk("t3b_prod_a", {16'd0, a_product}, 32'h0018);
    chk("t3b_prod_e", {16'd0, e_product}, 32'h0010);
    step();
    chk("t3_drained", {31'd0, a_out_valid}, 32'd0);

    // Test 4: back-to-back stream at full throughput
    for (int c = 0; c < 8; c++) begin
      if (c < 5) begin
        chk("t4_in_ready", {31'd0, a_in_ready}, 32'd1);
        in_valid = 1'b1;
        row_a    = 16'h0010 + 16'(c);
        row_b    = 16'h0020;
      end else begin
        in_valid = 1'b0;
      end
      if (c >= 2 && c <= 6) begin
        chk("t4_valid", {31'd0, a_out_valid}, 32'd1);
        chk("t4_prod",  {16'd0, a_product}, 32'h0030 + 32'(c - 2));
      end else begin
        chk("t4_idle", {31'd0, a_out_valid}, 32'd0);
      end
      step();
    end

    // Test 5: stall with three inputs offered
    out_ready = 1'b0;
    chk("t5_rdy0", {31'd0, a_in_ready}, 32'd1);
    in_valid = 1'b1; row_a = 16'h0100; row_b = 16'h0001;
    step();
    chk("t5_rdy1", {31'd0, a_in_ready}, 32'd1);
    row_a = 16'h0200; row_b = 16'h0002;
    step();
    chk("t5_rdy2",  {31'd0, a_in_ready}, 32'd0);
    chk("t5_hold2", {16'd0, a_product},  32'h0101);
    row_a = 16'h0300; row_b = 16'h0003;
    step();
    chk("t5_rdy3",  {31'd0, a_in_ready}, 32'd0);
    chk("t5_hold3", {16'd0, a_product},  32'h0101);
    chk("t5_val3",  {31'd0, a_out_valid}, 32'd1);
    step();
    chk("t5_hold4", {16'd0, a_product},  32'h0101);
    out_ready = 1'b1;
    #1;
    chk("t5_rdy_comb", {31'd0, a_in_ready}, 32'd1);
    step();
    in_valid = 1'b0;
    chk("t5_out1", {16'd0, a_product}, 32'h0202);
    chk("t5_val1", {31'd0, a_out_valid}, 32'd1);
    step();
    chk("t5_out2", {16'd0, a_product}, 32'h0303);
    chk("t5_val2", {31'd0, e_out_valid}, 32'd1);
    step();
    chk("t5_done", {31'd0, a_out_valid}, 32'd0);

    // Test 6: asynchronous reset with both stages full
    out_ready = 1'b0;
    in_valid = 1'b1; row_a = 16'h1234; row_b = 16'h0101;
    step();
    row_a = 16'h4321; row_b = 16'h0101;
    step();
    in_valid = 1'b0;
    chk("t6_full_valid", {31'd0, a_out_valid}, 32'd1);
    chk("t6_full_prod",  {16'd0, a_product},  32'h1335);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", {31'd0, a_out_valid}, 32'd0);
    chk("t6_rst_prod",  {16'd0, a_product},  32'h0000);
    chk("t6_rst_prod_e", {16'd0, e_product}, 32'h0000);
    chk("t6_rst_rdy",   {31'd0, a_in_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      chk("t6_no_stale", {31'd0, a_out_valid}, 32'd0);
      chk("t6_rdy",      {31'd0, a_in_ready},  32'd1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/approx_wallace_final_adder_pipe.md
Name: approx_wallace_final_adder_pipe

Overview:
- Downstream consumer of the last approximate Wallace reduction layer of the 8-bit multiplier.
- Takes the two remaining 16-bit partial-product rows and produces the final 16-bit product.
- Uses a two-stage pipelined carry-propagate adder. The low APPROX_LSBS bits use a lower-part-OR approximation.
- Valid/ready handshakes on both sides decouple the combinational tree from the downstream accumulator.

Parameters:
- APPROX_LSBS, 4, number of low result bits computed approximately; legal range 0..8; 0 = exact adder.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  row_a/row_b valid this cycle.
- in_ready  output  1  block accepts input this cycle.
- row_a  input  16  reduced row A (weights 2^0..2^15).
- row_b  input  16  reduced row B (weights 2^0..2^15).
- out_valid  output  1  product/out_ovf valid.
- out_ready  input  1  downstream accepts output.
- product  output  16  final (approximate) product.
- out_ovf  output  1  carry out of bit 15.

Behaviour:
- Clock and reset: one clock, clk. Reset is rst_n, asynchronous assert, active-low.
- Reset values: while rst_n = 0, s1_valid = 0, s2_valid = 0, out_valid = 0, product = 16'h0000, out_ovf = 0. Data registers in stage 1 also clear to 0.
- Transfers: an input transfer occurs when in_valid && in_ready. An output transfer occurs when out_valid && out_ready.
- Approximate region, bits [L-1:0] with L = APPROX_LSBS:
  - sum[i] = row_a[i] | row_b[i].
  - Carry into bit L = row_a[L-1] & row_b[L-1] if L > 0, else 0.
- Exact region, bits [15:L]: ripple or any exact adder of row_a[15:L] + row_b[15:L] + the carry above. Carry out of bit 15 drives out_ovf.
- Stage 1, captured on an input transfer:
  - lo_sum[7:0]: result bits 7:0, computed per the two rules above.
  - c8: carry out of bit 7.
  - hi_a = row_a[15:8], hi_b = row_b[15:8].
  - Sets s1_valid.
- Stage 2, captured on a stage-1 advance:
  - product[15:8] = hi_a + hi_b + c8.
  - product[7:0] = lo_sum.
  - out_ovf = carry out.
  - Sets s2_valid. out_valid = s2_valid.
- Advance rules, one pipeline stage each:
  - s2_free = !s2_valid || out_ready.
  - s1 advances when s1_valid && s2_free.
  - in_ready = !s1_valid || s2_free. A combinational out_ready-to-in_ready path is allowed.
  - s1_valid next = input transfer ? 1 : (s1 advance ? 0 : s1_valid).
  - s2_valid next = s1 advance ? 1 : (output transfer ? 0 : s2_valid).
- Latency and throughput: 2 cycles from input transfer to out_valid with out_ready held high. Throughput is 1 result per cycle.
- Stall: while out_valid && !out_ready, product and out_ovf hold stable. Stage 1 may still fill once; after that in_ready = 0.
- Simultaneous events:
  - Input transfer and s1 advance in the same cycle: stage 1 reloads with new data and s1_valid stays 1.
  - Output transfer and s1 advance in the same cycle: stage 2 reloads and s2_valid stays 1.
- Reset mid-operation: all in-flight data is dropped with no partial output. The first cycle after deassert has in_ready = 1 and out_valid = 0.
- Data stability: row_a/row_b are sampled only on an input transfer. Values presented while in_ready = 0 are ignored.
- Width rule: no truncation inside the pipeline. The 17-bit sum is split into product[15:0] and out_ovf.

Test Plan:
1. Reset, then APPROX_LSBS=0, row_a=16'h00FF, row_b=16'h0001, out_ready=1 -> exactly 2 cycles later out_valid=1, product=16'h0100, out_ovf=0 (c8 crosses the stage boundary).
2. APPROX_LSBS=0, row_a=16'hFFFF, row_b=16'h0001 -> product=16'h0000, out_ovf=1. With APPROX_LSBS=4 and the same inputs -> product=16'hFFFF, out_ovf=0.
3. APPROX_LSBS=4, row_a=16'h0003, row_b=16'h0001 -> product=16'h0003 (exact 4). Then row_a=16'h0008, row_b=16'h0008 -> product=16'h0018 (carry a3&b3 injected at bit 4).
4. Back-to-back 5 inputs (0x0010+k, 0x0020) with out_ready=1 -> 5 consecutive out_valid cycles in order, product=0x0030+k, in_ready never low.
5. Stall: out_ready=0 for 4 cycles while feeding 3 inputs -> first two accepted, in_ready=0 on the third, product held constant. Raise out_ready -> all 3 results emerge in order with none lost or duplicated.
6. Assert rst_n=0 asynchronously mid-cycle with both stages full -> out_valid and product clear immediately without waiting for a clock edge. After release, no stale output appears and in_ready=1.
